// File: rtl/spi_txn_arbiter_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM encoding,
// default frame/timeout sizes and the round-robin pointer helper.
package spi_txn_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_DW      = 24;
    localparam int DEF_TIMEOUT = 4096;

    // Pointer advance past the served requester, wrapping for any NREQ.
    function automatic int rr_next(input int idx, input int n);
        if (idx >= n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin selector: first active request at or after ptr.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    int unsigned     cand_int_s;
    logic [IW-1:0]   cand_s;
    logic            found_s;

    // Scan requesters starting at ptr, keeping the first hit.
    always_comb begin
        grant      = '0;
        idx        = '0;
        found_s    = 1'b0;
        cand_int_s = 32'd0;
        cand_s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_int_s = (32'(ptr) + 32'(i)) % 32'(NREQ);
            cand_s     = IW'(cand_int_s);
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master among NREQ requesters: round-robin grant, one frame
// per grant, timeout abort, and a one-cycle ack/err completion pulse.
module spi_txn_arbiter
    import spi_txn_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               i_clk,
    input  logic               i_rstb,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*DW-1:0] i_req_data,
    output logic [NREQ-1:0]    o_ack,
    output logic               o_err,
    output logic [DW-1:0]      o_rdata,
    output logic               o_busy,
    output logic               o_tx_start,
    output logic [DW-1:0]      o_tx_data,
    input  logic               i_tx_end,
    input  logic [DW-1:0]      i_rx_data
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t      state_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   gidx_r;
    logic [NREQ-1:0] gnt_r;
    logic [CW-1:0]   cnt_r;
    logic [NREQ-1:0] pick_gnt_s;
    logic [IW-1:0]   pick_idx_s;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req   (i_req),
        .ptr   (ptr_r),
        .grant (pick_gnt_s),
        .idx   (pick_idx_s)
    );

    // Transaction FSM; every output is registered. o_err doubles as the
    // error flag since it is only ever raised on the edge entering DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            gidx_r     <= '0;
            gnt_r      <= '0;
            cnt_r      <= '0;
            o_ack      <= '0;
            o_err      <= 1'b0;
            o_rdata    <= '0;
            o_busy     <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_ack <= '0;
                    o_err <= 1'b0;
                    if (|i_req) begin
                        gidx_r     <= pick_idx_s;
                        gnt_r      <= pick_gnt_s;
                        o_tx_data  <= i_req_data[int'(pick_idx_s)*DW +: DW];
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state_r    <= ST_START;
                    end else begin
                        o_tx_start <= 1'b0;
                        o_busy     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_START: begin
                    o_tx_start <= 1'b0;
                    cnt_r      <= '0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real end pulse wins over a timeout on the same cycle.
                    if (i_tx_end) begin
                        o_rdata <= i_rx_data;
                        o_ack   <= gnt_r;
                        state_r <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        o_rdata <= '0;
                        o_err   <= 1'b1;
                        o_ack   <= gnt_r;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    o_ack   <= '0;
                    o_err   <= 1'b0;
                    o_busy  <= 1'b0;
                    ptr_r   <= IW'(rr_next(int'(gidx_r), NREQ));
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_ack      <= '0;
                    o_err      <= 1'b0;
                    o_busy     <= 1'b0;
                    o_tx_start <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing the SPI master (2..8).
REQ-002 Parameter DW, default 24: SPI frame width in bits.
REQ-003 Parameter TIMEOUT, default 4096: maximum number of WAIT cycles before a transaction is aborted.
REQ-004 i_clk  in  1: the single clock; the block SHALL run entirely in this domain. Reset is synchronous and active-low.
REQ-005 i_rstb  in  1: active-low reset, sampled on rising i_clk.
REQ-006 i_req  in  NREQ: per-requester request level; held high until the matching o_ack.
REQ-007 i_req_data  in  NREQ*DW: per-requester TX frame; slice n is bits [n*DW +: DW].
REQ-008 o_ack  out  NREQ: one-cycle completion pulse for the granted requester.
REQ-009 o_err  out  1: one-cycle pulse coincident with o_ack when the transaction timed out.
REQ-010 o_rdata  out  DW: RX frame of the last completed transaction; valid while o_ack is high.
REQ-011 o_busy  out  1: high in every state except IDLE.
REQ-012 o_tx_start  out  1: one-cycle start pulse to the SPI master.
REQ-013 o_tx_data  out  DW: frame to the SPI master; stable from o_tx_start until completion.
REQ-014 i_tx_end  in  1: one-cycle end pulse from the SPI master.
REQ-015 i_rx_data  in  DW: received frame from the SPI master; valid with i_tx_end.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT and DONE.
REQ-017 IDLE: when any i_req bit is high, the block SHALL select the winner round-robin starting at index ptr, latch that index and its i_req_data slice into o_tx_data, and go to START; otherwise it SHALL stay in IDLE.
REQ-018 START: o_tx_start SHALL be high for exactly this one cycle; next state WAIT.
REQ-019 WAIT: a per-transaction cycle counter SHALL clear on entry and increment each cycle.
REQ-020 WAIT, i_tx_end high: o_rdata SHALL take i_rx_data; next state DONE.
REQ-021 WAIT, counter reaching TIMEOUT-1 with no i_tx_end: o_rdata SHALL be set to 0 and the error flag set; next state DONE.
REQ-022 WAIT, i_tx_end on the same cycle as the timeout: i_tx_end SHALL win and no error is reported.
REQ-023 DONE: o_ack[g] SHALL be high for this one cycle only, with o_err high if the error flag is set; ptr SHALL become (g+1) mod NREQ; next state IDLE.
REQ-024 Latency: i_req rising in IDLE at cycle 0 -> o_tx_start at cycle 1 -> o_ack one cycle after the cycle in which i_tx_end is sampled.
REQ-025 i_tx_end in IDLE, START or DONE SHALL be ignored.
REQ-026 A requester dropping i_req mid-transaction SHALL NOT abort the transaction; o_ack is still issued.
REQ-027 i_req_data changes after the grant SHALL NOT affect o_tx_data.
REQ-028 The DONE state guarantees i_req is not re-sampled before the requester has seen o_ack, so no requester is served twice for one request.

Reset
REQ-029 When i_rstb is low at a rising edge, the block SHALL enter IDLE and clear ptr, the counter and the error flag, and drive o_ack=0, o_err=0, o_busy=0, o_tx_start=0, o_tx_data=0 and o_rdata=0.
REQ-030 Reset mid-transaction SHALL abandon the transaction without issuing o_ack; the SPI master is reset by the same i_rstb.

Structure
REQ-031 The FSM state encoding and the default DW/TIMEOUT values SHALL live in the shared spi package.
REQ-032 The round-robin selector SHALL be a separate sub-module, rr_pick (inputs: req vector and ptr; outputs: one-hot grant and index; combinational).
REQ-033 The counter width SHALL be clog2(TIMEOUT).

Verification
REQ-034 Single request: i_req=01, data0=0x00D000; stub returns i_tx_end with i_rx_data=0x0000A5 ten cycles after start -> o_tx_start at cycle 1, o_tx_data=0x00D000, o_ack=01 with o_rdata=0x0000A5, o_err=0.
REQ-035 Contention: i_req=11 held from reset with ptr=0 -> grant order 0,1,0,1 over four transactions, each o_ack one cycle long.
REQ-036 Timeout: TIMEOUT=16, stub never sends i_tx_end -> o_ack and o_err together 16 cycles after entering WAIT, o_rdata=0; the next request proceeds normally.
REQ-037 Tie: i_tx_end on the final WAIT cycle -> o_err=0, o_rdata=i_rx_data.
REQ-038 Reset in WAIT: i_rstb low for one cycle -> all outputs 0, no o_ack issued, o_busy=0 on the next cycle.
REQ-039 Spurious i_tx_end pulses in IDLE -> no o_ack and no change to o_rdata.
